// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request, fills the IF/ID
// register, absorbs one in-flight word in a skid entry under stall, and squashes redirected fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch,
  input  logic [31:0] branch_address,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_ins,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {RUN, SQUASH} state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc_n, if_id_ins_n, if_id_pc_n;
  logic              if_id_valid_n;
  logic [XLEN-1:0]   skid_ins, skid_ins_n, skid_pc, skid_pc_n;
  logic              skid_full, skid_full_n;
  logic [XLEN-1:0]   sq_addr, sq_addr_n;
  logic              imem_req_n;
  logic [XLEN-1:0]   imem_addr_n;
  logic              xfer_c;
  logic [XLEN-1:0]   target_c;

  assign xfer_c   = imem_req && imem_ready;
  assign target_c = {branch_address[XLEN-1:2], 2'b00};

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    if_id_ins_n   = if_id_ins;
    if_id_pc_n    = if_id_pc;
    if_id_valid_n = if_id_valid;
    skid_ins_n    = skid_ins;
    skid_pc_n     = skid_pc;
    skid_full_n   = skid_full;
    sq_addr_n     = sq_addr;

    unique case (state)
      RUN: begin
        if (stall) begin
          // Word arriving while ID holds is parked so the request can retire
          if (xfer_c) begin
            skid_ins_n  = imem_rdata;
            skid_pc_n   = imem_addr;
            skid_full_n = 1'b1;
            pc_n        = pc + XLEN'(4);
          end
        end else if (branch) begin
          if_id_valid_n = 1'b0;
          skid_full_n   = 1'b0;
          pc_n          = target_c;
          if (imem_req && !imem_ready) begin
            state_n   = SQUASH;
            sq_addr_n = imem_addr;
          end
        end else if (skid_full) begin
          if_id_ins_n   = skid_ins;
          if_id_pc_n    = skid_pc;
          if_id_valid_n = 1'b1;
          skid_full_n   = 1'b0;
        end else if (xfer_c) begin
          if_id_ins_n   = imem_rdata;
          if_id_pc_n    = imem_addr;
          if_id_valid_n = 1'b1;
          pc_n          = pc + XLEN'(4);
        end else begin
          if_id_valid_n = 1'b0;
        end
      end
      SQUASH: begin
        // Stale request must still complete; only the fetch target may move
        if (branch && !stall) pc_n = target_c;
        if (xfer_c) state_n = RUN;
      end
      default: state_n = RUN;
    endcase

    imem_req_n  = (state_n == SQUASH) ? 1'b1 : !skid_full_n;
    imem_addr_n = (state_n == SQUASH) ? sq_addr_n : pc_n;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_ins   <= '0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      skid_ins    <= '0;
      skid_pc     <= '0;
      skid_full   <= 1'b0;
      sq_addr     <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_id_ins   <= if_id_ins_n;
      if_id_pc    <= if_id_pc_n;
      if_id_valid <= if_id_valid_n;
      skid_ins    <= skid_ins_n;
      skid_pc     <= skid_pc_n;
      skid_full   <= skid_full_n;
      sq_addr     <= sq_addr_n;
      imem_req    <= imem_req_n;
      imem_addr   <= imem_addr_n;
    end
  end

endmodule
